// File: rtl/fp_to_fixed_iter.sv
// Multi-cycle float-to-signed-fixed converter; alignment shifts one bit per cycle under start/busy/done.
// Optional build macro FP2FX_ROUND_EN selects round-half-to-even; otherwise magnitudes truncate toward zero.
module fp_to_fixed_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int OUT_W = 32,
  parameter int SF_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] float_in,
  input  logic [SF_W-1:0]      scaling_factor,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_W-1:0]     fixed_out,
  output logic                 overflow,
  output logic                 inexact,
  output logic                 invalid
);
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int MW   = OUT_W + 1;
  localparam int NW   = $clog2(OUT_W + MAN_W + 4);
  localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;
  state_t r_state, w_stateNext;

  logic [NW-1:0]    r_n;
  logic [OUT_W:0]   r_mag;
  logic             r_g, r_r, r_s;
  logic             r_sign, r_left, r_nan, r_forceSat, r_forceZero, r_forceInexact;
  logic             r_busy, r_done, r_ovf, r_inx, r_inv;
  logic [OUT_W-1:0] r_fixed;

  logic [EXP_W-1:0] w_expField;
  logic [MAN_W-1:0] w_manField;
  logic             w_expZero, w_expOnes;
  logic [OUT_W:0]   w_mag;
  int               w_sfEff, w_k, w_nInt;
  logic             w_left, w_nan, w_forceSat, w_forceZero, w_forceInexact;

  logic             w_roundUp, w_inexactRaw;
  logic [OUT_W:0]   w_magRnd;
  logic [OUT_W-1:0] w_fixedNext;
  logic             w_ovfNext, w_inxNext, w_invNext;

  assign w_expField = float_in[MAN_W +: EXP_W];
  assign w_manField = float_in[MAN_W-1:0];
  assign w_expZero  = (w_expField == '0);
  assign w_expOnes  = (w_expField == '1);
  assign w_mag      = {{(OUT_W-MAN_W){1'b0}}, ~w_expZero, w_manField};

  // Classify the incoming operand and work out shift direction/count; out-of-range shifts collapse to n=0.
  always_comb begin
    w_sfEff        = (int'(scaling_factor) > OUT_W-1) ? OUT_W-1 : int'(scaling_factor);
    w_k            = (w_expZero ? 1 : int'(w_expField)) - BIAS + w_sfEff - MAN_W;
    w_nInt         = 0;
    w_left         = 1'b0;
    w_nan          = 1'b0;
    w_forceSat     = 1'b0;
    w_forceZero    = 1'b0;
    w_forceInexact = 1'b0;
    if (w_expOnes) begin
      w_nan      = (w_manField != '0);
      w_forceSat = (w_manField == '0);
    end else if (w_expZero && (w_manField == '0)) begin
      w_forceZero = 1'b1;
    end else if (w_k > OUT_W-MAN_W) begin
      w_forceSat = 1'b1;
    end else if (-w_k > MAN_W+2) begin
      w_forceZero    = 1'b1;
      w_forceInexact = |w_mag;
    end else if (w_k >= 0) begin
      w_left = 1'b1;
      w_nInt = w_k;
    end else begin
      w_nInt = -w_k;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = SHIFT;
      SHIFT:   if (r_n == '0) w_stateNext = ROUND;
      ROUND:   w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Final rounding, sign application and saturation of the aligned magnitude.
  always_comb begin
    w_inexactRaw = r_g | r_r | r_s;
`ifdef FP2FX_ROUND_EN
    w_roundUp    = r_g & (r_r | r_s | r_mag[0]);
`else
    w_roundUp    = 1'b0;
`endif
    w_magRnd     = r_mag + MW'(w_roundUp);
    w_fixedNext  = '0;
    w_ovfNext    = 1'b0;
    w_inxNext    = 1'b0;
    w_invNext    = 1'b0;
    if (r_nan) begin
      w_invNext = 1'b1;
    end else if (r_forceSat) begin
      w_fixedNext = r_sign ? SAT_NEG : SAT_POS;
      w_ovfNext   = 1'b1;
    end else if (r_forceZero) begin
      w_inxNext = r_forceInexact;
    end else if (!r_sign && (w_magRnd > POS_LIM)) begin
      w_fixedNext = SAT_POS;
      w_ovfNext   = 1'b1;
    end else if (r_sign && (w_magRnd > NEG_LIM)) begin
      w_fixedNext = SAT_NEG;
      w_ovfNext   = 1'b1;
    end else begin
      w_fixedNext = r_sign ? -w_magRnd[OUT_W-1:0] : w_magRnd[OUT_W-1:0];
      w_inxNext   = w_inexactRaw;
    end
  end

  // Right shifts push bits through guard then round, and everything below round folds into sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n            <= '0;
      r_mag          <= '0;
      r_g            <= 1'b0;
      r_r            <= 1'b0;
      r_s            <= 1'b0;
      r_sign         <= 1'b0;
      r_left         <= 1'b0;
      r_nan          <= 1'b0;
      r_forceSat     <= 1'b0;
      r_forceZero    <= 1'b0;
      r_forceInexact <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fixed        <= '0;
      r_ovf          <= 1'b0;
      r_inx          <= 1'b0;
      r_inv          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n            <= NW'(w_nInt);
            r_mag          <= w_mag;
            r_g            <= 1'b0;
            r_r            <= 1'b0;
            r_s            <= 1'b0;
            r_sign         <= float_in[EXP_W+MAN_W];
            r_left         <= w_left;
            r_nan          <= w_nan;
            r_forceSat     <= w_forceSat;
            r_forceZero    <= w_forceZero;
            r_forceInexact <= w_forceInexact;
            r_busy         <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_n != '0) begin
            r_n <= r_n - NW'(1);
            if (r_left) begin
              r_mag <= r_mag << 1;
            end else begin
              {r_mag, r_g, r_r} <= {1'b0, r_mag, r_g};
              r_s               <= r_s | r_r;
            end
          end
        end
        ROUND: begin
          r_fixed <= w_fixedNext;
          r_ovf   <= w_ovfNext;
          r_inx   <= w_inxNext;
          r_inv   <= w_invNext;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fixed_out = r_fixed;
  assign overflow  = r_ovf;
  assign inexact   = r_inx;
  assign invalid   = r_inv;
endmodule

// File: doc/fp_to_fixed_iter.md
# fp_to_fixed_iter

Parametrised, multi-cycle floating-point-to-fixed-point converter: the generalised successor of the FP16 fixed converter in the vector processor's format-conversion path. It accepts an IEEE-style binary float of configurable exponent/mantissa width and a per-operation scaling factor. It produces a two's-complement signed fixed-point word with rounding, saturation and status flags. Alignment uses a one-bit-per-cycle shifter under a start/busy/done handshake.

## Interface
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 10, stored mantissa width
- OUT_W, 32, fixed-point output width (signed, two's complement)
- SF_W, 6, scaling-factor input width
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request; accepted only when busy=0
- float_in  input  1+EXP_W+MAN_W  {sign, exponent, mantissa}
- scaling_factor  input  SF_W  fraction bits of output; values > OUT_W-1 clamp to OUT_W-1
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; result and flags valid
- fixed_out  output  OUT_W  result, held until the next done
- overflow  output  1  result saturated (incl. ±Inf)
- inexact  output  1  nonzero bits discarded
- invalid  output  1  input was NaN

## Operation
- States: IDLE, SHIFT, ROUND. Reset state is IDLE. On reset, every output is 0.
- IDLE with start=1: float_in and scaling_factor are captured. busy goes to 1. State becomes SHIFT.
- Decode on capture:
  - normal: mag = {1, man}, e = exp - bias.
  - subnormal (exp=0): mag = {0, man}, e = 1 - bias.
  - zero → n=0, result 0.
  - Inf → n=0, saturate, overflow=1.
  - NaN (exp all-ones, man≠0) → n=0, result 0, invalid=1.
- Shift amount: k = e + sf - MAN_W.
  - k ≥ 0: left shift by n = k.
  - k < 0: right shift by n = -k.
- Clamps:
  - k > OUT_W-MAN_W: n=0, saturate, overflow=1.
  - -k > MAN_W+2: n=0, result 0, inexact = (mag≠0).
- Right shifts keep guard and round bits plus a sticky OR of every bit shifted out. Magnitude register width is OUT_W+1.
- SHIFT: one bit per cycle while n≠0, with n decremented each cycle. At n=0 the state moves to ROUND.
- ROUND:
  - Apply the rounding rule (see Configuration).
  - Negate if sign=1.
  - Saturate: positive magnitude > 2^(OUT_W-1)-1 → 0x7FF…F. Negative magnitude > 2^(OUT_W-1) → 0x800…0. Both set overflow=1.
  - -2^(OUT_W-1) is exact and is not an overflow.
  - Register fixed_out and the flags, pulse done, clear busy, return to IDLE.
- Flags are mutually consistent: overflow results set inexact=0, and invalid results set overflow=0.
- Negative zero and results that round to zero output 0 (no negative zero).

## Timing
- Acceptance edge T0 (start=1, state IDLE). ROUND is entered at edge T0+n+1. done=1 in the cycle after edge T0+n+2. Latency is n+2 cycles.
- Special and clamped cases have n=0, so latency is 2.
- busy=1 from after T0 until done rises; busy=0 in the done cycle.
- start while busy=1 is ignored, with no queueing.
- start in the done cycle (state IDLE) is accepted. done falls next cycle. fixed_out keeps its old value until the new done.
- Inputs are sampled only at acceptance; later changes do not affect the conversion in flight.
- rst_n=0 in any state (including mid-SHIFT): next edge state=IDLE, all outputs 0, and the in-flight operation is discarded with no done.

## Configuration
- FP2FX_ROUND_EN defined: round-half-to-even, using guard/round/sticky plus the LSB.
- FP2FX_ROUND_EN undefined: magnitude truncation (round toward zero).
- inexact is reported identically in both builds.

## Test plan
- 0x3C00 (1.0), sf=16 → fixed_out=0x00010000, n=6, done 8 cycles after acceptance, all flags 0.
- 0xC500 (-5.0), sf=0 → 0xFFFFFFFB, n=8, inexact=0.
- 0x3E00 (1.5), sf=0 → 0x00000002 with FP2FX_ROUND_EN, 0x00000001 without; inexact=1 in both builds.
- Saturation and special inputs:
  - 0x7BFF, sf=16 → 0x7FFFFFFF, overflow=1, latency 23.
  - 0xFC00 (-Inf) → 0x80000000, overflow=1, latency 2.
  - 0x7E00 (NaN) → 0, invalid=1.
- Subnormals: 0x0001, sf=24 → 0x00000001 exact. 0x0001, sf=0 → 0, inexact=1, latency 2.
- Handshake and reset:
  - A second start pulse during SHIFT is ignored, with exactly one done.
  - rst_n low mid-SHIFT → busy=0, done never pulses, outputs 0.
  - A new start after reset converts correctly.
